// File: rtl/twofish_block_loader_pkg.sv
// Shared widths, loader state encoding and word-slicing helper for the
// Twofish block loader.
package twofish_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } loader_state_t;

  // Word idx of a group lands at bits [32*(3-idx) +: 32] once the group is complete.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         idx);
    block_word = blk[WORD_W*(WORDS_PER_BLOCK-1-int'(idx)) +: WORD_W];
  endfunction

endpackage

// File: rtl/twofish_block_loader_if.sv
// Stream and core-operand bundle between the loader and its neighbours.
// slave = loader side, master = source/sink/core side.
interface twofish_block_loader_if;
  import twofish_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               in_key;
  logic [BLOCK_W-1:0] core_plain;
  logic [BLOCK_W-1:0] core_key;
  logic [BLOCK_W-1:0] core_cipher;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               err_drop;

  modport master (
    output in_valid, in_data, in_key, out_ready, core_cipher,
    input  in_ready, core_plain, core_key, out_valid, out_data, err_drop
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready, core_cipher,
    output in_ready, core_plain, core_key, out_valid, out_data, err_drop
  );

endinterface

// File: rtl/twofish_word_assembler.sv
// 4x32 shift register with word count and full flag; first word ends up in
// the top slice. Clear together with shift restarts the group at count 1.
module twofish_word_assembler
  import twofish_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_shift,
  input  logic [WORD_W-1:0]  i_word,
  output logic [BLOCK_W-1:0] o_data,
  output logic [1:0]         o_cnt,
  output logic               o_full
);

  logic [BLOCK_W-1:0] r_data;
  logic [1:0]         r_cnt;
  logic               r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= 2'd0;
      r_full <= 1'b0;
    end else begin
      if (i_shift) begin
        r_data <= {r_data[BLOCK_W-WORD_W-1:0], i_word};
      end
      if (i_clr) begin
        r_cnt  <= i_shift ? 2'd1 : 2'd0;
        r_full <= 1'b0;
      end else if (i_shift) begin
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          r_full <= 1'b1;
        end
      end
    end
  end

  assign o_data = r_data;
  assign o_cnt  = r_cnt;
  assign o_full = r_full;

endmodule

// File: rtl/twofish_block_loader.sv
// Assembles key/plaintext words for the combinational Twofish core, waits a
// fixed settle window, then registers the ciphertext. `TWOFISH_CBC_EN selects CBC.
module twofish_block_loader
  import twofish_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  twofish_block_loader_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  loader_state_t      r_state;
  loader_state_t      w_state_nxt;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [BLOCK_W-1:0] r_out_data;
  logic               r_err_drop;

  logic [BLOCK_W-1:0] w_key_data;
  logic [BLOCK_W-1:0] w_txt_data;
  logic [1:0]         w_key_cnt;
  logic [1:0]         w_txt_cnt;
  logic               w_key_full;
  logic               w_txt_full;
  logic [WORD_W-1:0]  w_txt_word_in;

  logic w_accept, w_key_word, w_txt_word, w_drop, w_new_key;
  logic w_txt_last, w_capture, w_release;

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_key_word = w_accept & bus.in_key;
  assign w_txt_word = w_accept & ~bus.in_key & w_key_full & ~w_txt_full;
  assign w_drop     = w_accept & ~bus.in_key & ~w_key_full;
  // A full key always has its count wrapped back to zero.
  assign w_new_key  = w_key_word & w_key_full & (w_key_cnt == 2'd0);
  assign w_txt_last = w_txt_word & (w_txt_cnt == 2'd3);
  assign w_capture  = (r_state == SETTLE) & (r_settle_cnt == '0);
  assign w_release  = (r_state == HOLD) & r_out_valid & bus.out_ready;

`ifdef TWOFISH_CBC_EN
  logic [BLOCK_W-1:0] r_chain;

  // Chain register: zero IV on reset or new key, previous ciphertext otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else if (w_new_key) begin
      r_chain <= '0;
    end else if (w_capture) begin
      r_chain <= bus.core_cipher;
    end
  end

  // Pre-XOR each word with its chain slice so the text register is the core operand.
  assign w_txt_word_in = bus.in_data ^ block_word(r_chain, w_txt_cnt);
`else
  assign w_txt_word_in = bus.in_data;
`endif

  twofish_word_assembler u_key (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_new_key),
    .i_shift (w_key_word),
    .i_word  (bus.in_data),
    .o_data  (w_key_data),
    .o_cnt   (w_key_cnt),
    .o_full  (w_key_full)
  );

  twofish_word_assembler u_txt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_new_key | w_release),
    .i_shift (w_txt_word),
    .i_word  (w_txt_word_in),
    .o_data  (w_txt_data),
    .o_cnt   (w_txt_cnt),
    .o_full  (w_txt_full)
  );

  // Next-state logic for the LOAD/SETTLE/HOLD sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_txt_last) w_state_nxt = SETTLE; else w_state_nxt = LOAD;
      SETTLE:  if (w_capture)  w_state_nxt = HOLD;   else w_state_nxt = SETTLE;
      HOLD:    if (w_release)  w_state_nxt = LOAD;   else w_state_nxt = HOLD;
      default: w_state_nxt = LOAD;
    endcase
  end

  // State, settle countdown, handshake flags and ciphertext capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD;
      r_settle_cnt <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_err_drop   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == LOAD);
      r_err_drop <= w_drop;
      if (w_txt_last) begin
        r_settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
      end else if ((r_state == SETTLE) && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_out_data  <= bus.core_cipher;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.core_plain = w_txt_data;
  assign bus.core_key   = w_key_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.err_drop   = r_err_drop;

endmodule

// File: tb/tb_twofish_block_loader.sv
// Directed bench for twofish_block_loader with the core stubbed as plain XOR key.
module tb_twofish_block_loader;
  import twofish_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [BLOCK_W-1:0] key_m   = '0;
  logic [BLOCK_W-1:0] chain_m = '0;

  twofish_block_loader_if bus();

  twofish_block_loader #(.SETTLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.core_cipher = bus.core_plain ^ bus.core_key;

  task automatic chk(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] exp_ct(input logic [BLOCK_W-1:0] p);
`ifdef TWOFISH_CBC_EN
    return p ^ chain_m ^ key_m;
`else
    return p ^ key_m;
`endif
  endfunction

  task automatic send(input logic k, input logic [WORD_W-1:0] d, output logic dropped);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_key   = k;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 128'(n), 128'd0);
    @(posedge clk);
    #1;
    dropped      = bus.err_drop;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [BLOCK_W-1:0] p);
    logic dr;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      send(1'b0, p[BLOCK_W-1-WORD_W*i -: WORD_W], dr);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_block(input string tag, input logic [BLOCK_W-1:0] p);
    int lat;
    logic [BLOCK_W-1:0] e;
    send_block(p);
    wait_out(lat);
    chk({tag, "_latency"}, 128'(lat), 128'd4);
    e = exp_ct(p);
    chk({tag, "_data"}, bus.out_data, e);
    chain_m = e;
    @(posedge clk);
    #1;
    chk({tag, "_valid_clr"}, 128'(bus.out_valid), 128'd0);
    chk({tag, "_ready_back"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    logic dr;
    int   lat;
    int   hs;
    int   seen;
    logic [BLOCK_W-1:0] held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_key    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   128'(bus.in_ready), 128'd0);
    chk("rst_out_valid",  128'(bus.out_valid), 128'd0);
    chk("rst_out_data",   bus.out_data, 128'd0);
    chk("rst_core_plain", bus.core_plain, 128'd0);
    chk("rst_core_key",   bus.core_key, 128'd0);
    chk("rst_err_drop",   128'(bus.err_drop), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 128'(bus.in_ready), 128'd1);

    // Plaintext before any key is dropped with a one-cycle pulse.
    send(1'b0, 32'h1111_1111, dr);
    chk("nokey_drop", 128'(dr), 128'd1);
    @(posedge clk);
    #1;
    chk("nokey_drop_pulse", 128'(bus.err_drop), 128'd0);
    chk("nokey_plain", bus.core_plain, 128'd0);

    send(1'b1, 32'h0000_0001, dr);
    send(1'b1, 32'h0000_0002, dr);
    send(1'b1, 32'h0000_0003, dr);
    send(1'b1, 32'h0000_0004, dr);
    key_m = 128'h00000001_00000002_00000003_00000004;
    chk("key_order", bus.core_key, key_m);

    // Word order with backpressure held in HOLD.
    bus.out_ready = 1'b0;
    send_block(128'hA0000000_A0000001_A0000002_A0000003);
    wait_out(lat);
    chk("order_latency", 128'(lat), 128'd4);
    chk("order_data", bus.out_data, 128'hA0000001_A0000003_A0000001_A0000007);
    chain_m = bus.out_data;
    held = bus.out_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_data_stable", bus.out_data, held);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
    end
    bus.out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) hs++;
    end
    chk("bp_handshakes", 128'(hs), 128'd1);
    chk("bp_ready_back", 128'(bus.in_ready), 128'd1);

    // Second block with the retained key.
    run_block("retained_key", 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);

    // Key restart mid-text discards the partial plaintext.
    send(1'b0, 32'hC000_0000, dr);
    send(1'b0, 32'hC000_0001, dr);
    send(1'b1, 32'h0000_0010, dr);
    chk("restart_no_drop", 128'(dr), 128'd0);
    chain_m = '0;
    send(1'b0, 32'hD000_0000, dr);
    chk("restart_drop", 128'(dr), 128'd1);
    send(1'b1, 32'h0000_0020, dr);
    send(1'b1, 32'h0000_0030, dr);
    send(1'b1, 32'h0000_0040, dr);
    key_m = 128'h00000010_00000020_00000030_00000040;
    chk("restart_key", bus.core_key, key_m);
    run_block("restart_blk", 128'hB0000000_B0000001_B0000002_B0000003);
`ifndef TWOFISH_CBC_EN
    chk("restart_const", bus.out_data, 128'hB0000010_B0000021_B0000032_B0000043);
`endif

    // Reset two cycles into SETTLE.
    send_block(128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready",   128'(bus.in_ready), 128'd0);
    chk("midrst_out_valid",  128'(bus.out_valid), 128'd0);
    chk("midrst_out_data",   bus.out_data, 128'd0);
    chk("midrst_core_plain", bus.core_plain, 128'd0);
    chk("midrst_core_key",   bus.core_key, 128'd0);
    chk("midrst_err_drop",   128'(bus.err_drop), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    key_m = '0;
    chain_m = '0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    chk("midrst_no_valid", 128'(seen), 128'd0);
    send(1'b0, 32'h5555_5555, dr);
    chk("midrst_key_lost", 128'(dr), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
